// File: rtl/lms_pkg.sv
// Shared types and defaults for the LMS adaptive-noise-cancel control path.
package lms_pkg;

  localparam int LMS_TAPS   = 8;
  localparam int LMS_ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILTER,
    DRAIN,
    ERROR,
    UPDATE,
    DONE
  } lms_seq_state_t;

endpackage

// File: rtl/lms_valid_pipe.sv
// Delay line that aligns a one-bit valid with the multiplier latency.
// DEPTH=0 degenerates to a plain wire.
module lms_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0] vld_p;

      // Shift the valid bit one stage per clock
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            vld_p[i] <= vld_p[i-1];
          end
        end
      end

      assign dout = vld_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lms_sequencer.sv
// Per-sample control FSM for the LMS noise canceller: one shared multiplier
// is walked across all taps for the filter pass, then again for the weight
// update. Outputs are registered from the next-state decode.
// Optional build macro LMS_SEQ_STATS_EN adds a saturating dropped-tick counter.
module lms_sequencer
  import lms_pkg::*;
#(
  parameter int TAPS    = LMS_TAPS,
  parameter int ADDR_W  = LMS_ADDR_W,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              adapt_en,
  input  logic              clr_overrun,
  output logic              hist_we,
  output logic [ADDR_W-1:0] hist_addr,
  output logic [ADDR_W-1:0] tap_idx,
  output logic              mul_issue,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              err_latch,
  output logic              w_we,
  output logic              out_valid,
  output logic              busy,
`ifdef LMS_SEQ_STATS_EN
  output logic              overrun,
  output logic [7:0]        overrun_cnt
`else
  output logic              overrun
`endif
);

  localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(TAPS - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);

  lms_seq_state_t    state, next_state;
  logic [ADDR_W-1:0] k, next_k;
  logic [2:0]        drain_cnt, next_drain;
  logic [ADDR_W-1:0] base_ptr;
  logic              tick_d;
  logic              tick_rise;
  logic              ov_set;

  logic              d_hist_we, d_mul_issue, d_acc_clr, d_err_latch, d_w_we, d_busy;
  logic [ADDR_W-1:0] d_hist_addr, d_tap_idx;

  assign tick_rise = sample_tick & ~tick_d;
  assign ov_set    = tick_rise & (state != IDLE);

  // State, tap counter, drain counter, tick edge detector and history base pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= '0;
      drain_cnt <= '0;
      tick_d    <= 1'b1;
      base_ptr  <= '0;
    end else begin
      state     <= next_state;
      k         <= next_k;
      drain_cnt <= next_drain;
      tick_d    <= sample_tick;
      if (state == DONE) begin
        base_ptr <= base_ptr + ADDR_W'(1);
      end
    end
  end

  // Next-state logic and output decode of the state being entered
  always_comb begin
    next_state  = state;
    next_k      = k;
    next_drain  = drain_cnt;
    d_hist_we   = 1'b0;
    d_mul_issue = 1'b0;
    d_acc_clr   = 1'b0;
    d_err_latch = 1'b0;
    d_w_we      = 1'b0;
    d_hist_addr = '0;
    d_tap_idx   = '0;

    case (state)
      IDLE: begin
        if (tick_rise) next_state = LOAD;
      end
      LOAD: begin
        next_state = FILTER;
        next_k     = '0;
      end
      FILTER: begin
        if (k == K_LAST) begin
          next_state = (MUL_LAT == 0) ? ERROR : DRAIN;
          next_drain = '0;
        end else begin
          next_k = k + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) next_state = ERROR;
        else                         next_drain = drain_cnt + 3'd1;
      end
      ERROR: begin
        if (adapt_en) begin
          next_state = UPDATE;
          next_k     = '0;
        end else begin
          next_state = DONE;
        end
      end
      UPDATE: begin
        if (k == K_LAST) next_state = DONE;
        else             next_k = k + ADDR_W'(1);
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    // History reads walk backwards from the newest sample; wrap is implicit
    case (next_state)
      LOAD: begin
        d_hist_we   = 1'b1;
        d_acc_clr   = 1'b1;
        d_hist_addr = base_ptr;
      end
      FILTER: begin
        d_mul_issue = 1'b1;
        d_tap_idx   = next_k;
        d_hist_addr = base_ptr - next_k;
      end
      ERROR: begin
        d_err_latch = 1'b1;
      end
      UPDATE: begin
        d_w_we      = 1'b1;
        d_tap_idx   = next_k;
        d_hist_addr = base_ptr - next_k;
      end
      default: ;
    endcase

    d_busy = (next_state != IDLE);
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_we   <= 1'b0;
      hist_addr <= '0;
      tap_idx   <= '0;
      mul_issue <= 1'b0;
      acc_clr   <= 1'b0;
      err_latch <= 1'b0;
      out_valid <= 1'b0;
      w_we      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      hist_we   <= d_hist_we;
      hist_addr <= d_hist_addr;
      tap_idx   <= d_tap_idx;
      mul_issue <= d_mul_issue;
      acc_clr   <= d_acc_clr;
      err_latch <= d_err_latch;
      out_valid <= d_err_latch;
      w_we      <= d_w_we;
      busy      <= d_busy;
    end
  end

  // Sticky overrun flag; a dropped tick outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (ov_set)      overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

`ifdef LMS_SEQ_STATS_EN
  // Saturating count of dropped ticks, same set-over-clear priority as the flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt <= '0;
    end else if (ov_set) begin
      if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end else if (clr_overrun) begin
      overrun_cnt <= '0;
    end
  end
`endif

  // Accumulate enable follows the issue strobe by the multiplier latency
  lms_valid_pipe #(
    .DEPTH (MUL_LAT)
  ) u_acc_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (mul_issue),
    .dout  (acc_en)
  );

endmodule

// File: tb/tb_lms_sequencer.sv
// Directed bench for lms_sequencer at default parameters (TAPS=8, MUL_LAT=1).
// Cycle 0 is the cycle in which the tick rising edge is seen by the DUT.
module tb_lms_sequencer;

  logic       clk = 1'b0;
  logic       reset, sample_tick, adapt_en, clr_overrun;
  logic       hist_we, mul_issue, acc_clr, acc_en, err_latch, w_we, out_valid, busy, overrun;
  logic [2:0] hist_addr, tap_idx;
`ifdef LMS_SEQ_STATS_EN
  logic [7:0] overrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic       c_we[64], c_clr[64], c_mul[64], c_acc[64], c_err[64], c_ov[64];
  logic       c_wwe[64], c_busy[64], c_ovr[64];
  logic [2:0] c_addr[64], c_tap[64];

  always #5 clk = ~clk;

  lms_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .adapt_en    (adapt_en),
    .clr_overrun (clr_overrun),
    .hist_we     (hist_we),
    .hist_addr   (hist_addr),
    .tap_idx     (tap_idx),
    .mul_issue   (mul_issue),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .err_latch   (err_latch),
    .w_we        (w_we),
    .out_valid   (out_valid),
    .busy        (busy),
`ifdef LMS_SEQ_STATS_EN
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
`else
    .overrun     (overrun)
`endif
  );

  function automatic logic [14:0] all_outs();
    return {hist_we, hist_addr, tap_idx, mul_issue, acc_clr, acc_en,
            err_latch, w_we, out_valid, busy, overrun};
  endfunction

  function automatic logic [2:0] waddr(input int base, input int k);
    return 3'((base - k + 8) % 8);
  endfunction

  task automatic record(input int c);
    c_we[c]   = hist_we;   c_clr[c]  = acc_clr;   c_mul[c]  = mul_issue;
    c_acc[c]  = acc_en;    c_err[c]  = err_latch; c_ov[c]   = out_valid;
    c_wwe[c]  = w_we;      c_busy[c] = busy;      c_ovr[c]  = overrun;
    c_addr[c] = hist_addr; c_tap[c]  = tap_idx;
  endtask

  task automatic begin_tick();
    @(posedge clk);
    #1 sample_tick = 1'b1;
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      record(c);
      if (c == 3) sample_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [14:0] o;
    reset = 1'b1; sample_tick = 1'b1; adapt_en = 1'b1; clr_overrun = 1'b0;
    #3 reset = 1'b0;
    @(negedge clk);
    o = all_outs();
    n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_hold: outs=%h expected 0", o); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      o = all_outs();
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_release_c%0d: outs=%h expected 0", c, o); end
    end
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_adapt();
    logic [8:0] got, exp;
    logic [2:0] ea, et;
    adapt_en = 1'b1;
    begin_tick();
    capture(30);
    for (int c = 0; c < 30; c++) begin
      exp = {c == 1, c == 1, c >= 2 && c <= 9, c >= 3 && c <= 10, c == 11, c == 11,
             c >= 12 && c <= 19, c >= 1 && c <= 20, 1'b0};
      got = {c_we[c], c_clr[c], c_mul[c], c_acc[c], c_err[c], c_ov[c], c_wwe[c], c_busy[c], c_ovr[c]};
      ea = 3'd0; et = 3'd0;
      if (c >= 2 && c <= 9)   begin ea = waddr(0, c - 2);  et = 3'(c - 2);  end
      if (c >= 12 && c <= 19) begin ea = waddr(0, c - 12); et = 3'(c - 12); end
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL adapt_ctrl_c%0d: got %b expected %b", c, got, exp); end
      n_checks++;
      if (c_addr[c] !== ea) begin n_fail++; $display("FAIL adapt_addr_c%0d: got %0d expected %0d", c, c_addr[c], ea); end
      n_checks++;
      if (c_tap[c] !== et) begin n_fail++; $display("FAIL adapt_tap_c%0d: got %0d expected %0d", c, c_tap[c], et); end
    end
  endtask

  task automatic test_single_freeze();
    logic [7:0] got, exp;
    logic [2:0] ea;
    adapt_en = 1'b0;
    begin_tick();
    capture(20);
    for (int c = 0; c < 20; c++) begin
      exp = {c == 1, c >= 2 && c <= 9, c >= 3 && c <= 10, c == 11, c == 11,
             1'b0, c >= 1 && c <= 12, 1'b0};
      got = {c_we[c], c_mul[c], c_acc[c], c_err[c], c_ov[c], c_wwe[c], c_busy[c], c_ovr[c]};
      ea = 3'd0;
      if (c == 1) ea = 3'd1;
      if (c >= 2 && c <= 9) ea = waddr(1, c - 2);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL freeze_ctrl_c%0d: got %b expected %b", c, got, exp); end
      n_checks++;
      if (c_addr[c] !== ea) begin n_fail++; $display("FAIL freeze_addr_c%0d: got %0d expected %0d", c, c_addr[c], ea); end
    end
    adapt_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    adapt_en = 1'b1;
    for (int t = 0; t < 9; t++) begin
      begin_tick();
      capture(40);
      n_checks++;
      if (c_we[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_load_t%0d: hist_we=%b expected 1", t, c_we[1]); end
      n_checks++;
      if (c_addr[1] !== waddr(t % 8, 0)) begin
        n_fail++; $display("FAIL b2b_addr_t%0d: got %0d expected %0d", t, c_addr[1], waddr(t % 8, 0));
      end
      n_checks++;
      if (c_ov[11] !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_t%0d: got %b expected 1", t, c_ov[11]); end
      n_checks++;
      if ({c_busy[20], c_busy[21]} !== 2'b10) begin
        n_fail++; $display("FAIL b2b_busy_t%0d: got %b expected 10", t, {c_busy[20], c_busy[21]});
      end
      n_checks++;
      if (c_ovr[39] !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_t%0d: got %b expected 0", t, c_ovr[39]); end
    end
  endtask

  task automatic test_overrun();
    int nwe, nbusy;
    adapt_en = 1'b1;
    begin_tick();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      record(c);
      if (c == 3)  sample_tick = 1'b0;
      if (c == 10) sample_tick = 1'b1;
      if (c == 13) sample_tick = 1'b0;
      if (c == 15) clr_overrun = 1'b1;
      if (c == 16) clr_overrun = 1'b0;
      if (c == 20) sample_tick = 1'b1;
      if (c == 23) sample_tick = 1'b0;
    end
    nwe = 0; nbusy = 0;
    for (int c = 0; c < 36; c++) nwe += int'(c_we[c]);
    for (int c = 21; c < 36; c++) nbusy += int'(c_busy[c]);
    n_checks++;
    if (c_addr[1] !== 3'd1) begin n_fail++; $display("FAIL ovr_load_addr: got %0d expected 1", c_addr[1]); end
    n_checks++;
    if ({c_ovr[10], c_ovr[11], c_ovr[15]} !== 3'b011) begin
      n_fail++; $display("FAIL ovr_set_filter: got %b expected 011", {c_ovr[10], c_ovr[11], c_ovr[15]});
    end
    n_checks++;
    if (c_ovr[16] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", c_ovr[16]); end
    n_checks++;
    if ({c_ovr[20], c_ovr[21], c_ovr[35]} !== 3'b011) begin
      n_fail++; $display("FAIL ovr_set_done: got %b expected 011", {c_ovr[20], c_ovr[21], c_ovr[35]});
    end
    n_checks++;
    if (nwe !== 1) begin n_fail++; $display("FAIL ovr_dropped_loads: got %0d hist_we cycles expected 1", nwe); end
    n_checks++;
    if (c_ov[11] !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b expected 1", c_ov[11]); end
    n_checks++;
    if (c_busy[20] !== 1'b1 || nbusy !== 0) begin
      n_fail++; $display("FAIL ovr_idle_after: busy20=%b busy_after=%0d expected 1 and 0", c_busy[20], nbusy);
    end
  endtask

  task automatic test_overrun_priority();
    begin_tick();
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      record(c);
      if (c == 3)  sample_tick = 1'b0;
      if (c == 6)  begin sample_tick = 1'b1; clr_overrun = 1'b1; end
      if (c == 7)  clr_overrun = 1'b0;
      if (c == 8)  sample_tick = 1'b0;
      if (c == 12) clr_overrun = 1'b1;
      if (c == 13) clr_overrun = 1'b0;
    end
    n_checks++;
    if (c_addr[1] !== 3'd2) begin n_fail++; $display("FAIL prio_load_addr: got %0d expected 2", c_addr[1]); end
    n_checks++;
    if ({c_ovr[6], c_ovr[7], c_ovr[12]} !== 3'b111) begin
      n_fail++; $display("FAIL prio_set_wins: got %b expected 111", {c_ovr[6], c_ovr[7], c_ovr[12]});
    end
    n_checks++;
    if (c_ovr[13] !== 1'b0) begin n_fail++; $display("FAIL prio_clear_alone: got %b expected 0", c_ovr[13]); end
  endtask

`ifdef LMS_SEQ_STATS_EN
  task automatic test_stats();
    @(negedge clk) clr_overrun = 1'b1;
    @(negedge clk) clr_overrun = 1'b0;
    n_checks++;
    if (overrun_cnt !== 8'd0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL stats_clear: cnt=%0d flag=%b expected 0 0", overrun_cnt, overrun);
    end
    begin_tick();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 11) begin
        n_checks++;
        if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL stats_one_drop: got %0d expected 1", overrun_cnt); end
      end
      if (c == 3)  sample_tick = 1'b0;
      if (c == 10) sample_tick = 1'b1;
      if (c == 13) sample_tick = 1'b0;
    end
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      sample_tick = ~sample_tick;
    end
    sample_tick = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL stats_saturate: got %0d expected 255", overrun_cnt); end
    @(negedge clk) clr_overrun = 1'b1;
    @(negedge clk) clr_overrun = 1'b0;
    n_checks++;
    if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_clear_after_sat: got %0d expected 0", overrun_cnt); end
  endtask
`endif

  task automatic test_async_reset();
    logic [14:0] o;
    adapt_en = 1'b1;
    begin_tick();
    capture(6);
    n_checks++;
    if (c_mul[5] !== 1'b1) begin n_fail++; $display("FAIL areset_in_filter: mul_issue=%b expected 1", c_mul[5]); end
    #2 reset = 1'b0;
    #1 o = all_outs();
    n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL areset_immediate: outs=%h expected 0", o); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    begin_tick();
    capture(12);
    n_checks++;
    if ({c_we[1], c_addr[1]} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL areset_restart_load: we=%b addr=%0d expected 1 0", c_we[1], c_addr[1]);
    end
    n_checks++;
    if ({c_addr[2], c_addr[3]} !== {3'd0, 3'd7}) begin
      n_fail++; $display("FAIL areset_restart_walk: got %0d,%0d expected 0,7", c_addr[2], c_addr[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_adapt();
    test_single_freeze();
    test_back_to_back();
    test_overrun();
    test_overrun_priority();
`ifdef LMS_SEQ_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
